// File: rtl/ctd_pkg.sv
// Shared definitions for the countdown-timer run-control slice:
// sequencer state encoding, default preset limit and preset clamp helper.
package ctd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } ctd_state_e;

    localparam int unsigned CTD_MAX_MIN = 99;

    function automatic logic [7:0] clamp_min(input logic [7:0] v, input int unsigned maxv);
        logic [7:0] lim;
        lim = 8'(maxv);
        return ({24'd0, v} > maxv) ? lim : v;
    endfunction

endpackage

// File: rtl/ctd_tick_div.sv
// Clock divider with synchronous clear and hold; o_wrap marks the last
// cycle of each DIV-cycle period while counting.
module ctd_tick_div #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_wrap
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_wrap = !i_hold && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/ctd_run_ctrl.sv
// Run-control sequencer for the min:sec countdown datapath: button handling,
// per-second count strobe, preset capture and timed alarm.
module ctd_run_ctrl
    import ctd_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned MAX_MIN     = CTD_MAX_MIN,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    input  logic [7:0] min_set,
    input  logic       time_out,
    output logic       load,
    output logic [7:0] min_Init,
    output logic       cnt_en,
    output logic       alarm,
    output logic       running,
    output logic       paused,
    output logic       err
);

    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_TICKS - 1);

    ctd_state_e    r_state;
    ctd_state_e    w_next;
    logic [7:0]    r_min;
    logic          r_err;
    logic          r_alarm;
    logic [AW-1:0] r_acnt;

    logic w_stop, w_pause, w_start;
    logic w_div_clr, w_div_hold, w_wrap;
    logic w_accept, w_reject;

    // stop > pause > start: a higher-priority pulse masks the lower ones
    assign w_stop  = btn_stop;
    assign w_pause = btn_pause && !btn_stop;
    assign w_start = btn_start && !btn_pause && !btn_stop;

    assign w_div_hold = !((r_state == ST_RUN) || (r_state == ST_ALARM));

    ctd_tick_div #(
        .DIV (TICK_DIV)
    ) u_div (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_div_clr),
        .i_hold (w_div_hold),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_div_clr = 1'b0;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (min_set != 8'd0) begin
                        w_accept = 1'b1;
                        w_next   = ST_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_div_clr = 1'b1;
                w_next    = ST_RUN;
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_next = ST_IDLE;
                end else if (time_out) begin
                    w_div_clr = 1'b1;
                    w_next    = ST_ALARM;
                end else if (w_pause) begin
                    w_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_stop) begin
                    w_next = ST_IDLE;
                end else if (w_start) begin
                    w_next = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (w_stop || (w_wrap && (r_acnt == ACNT_LAST))) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min   <= '0;
            r_err   <= 1'b0;
            r_alarm <= 1'b0;
            r_acnt  <= '0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_min <= clamp_min(min_set, MAX_MIN);
            end
            // entry counts as the first toggle; each later wrap toggles and counts
            if ((r_state != ST_ALARM) && (w_next == ST_ALARM)) begin
                r_alarm <= 1'b1;
                r_acnt  <= '0;
            end else if (r_state == ST_ALARM) begin
                if (w_next == ST_IDLE) begin
                    r_alarm <= 1'b0;
                    r_acnt  <= '0;
                end else if (w_wrap) begin
                    r_alarm <= !r_alarm;
                    r_acnt  <= r_acnt + AW'(1);
                end
            end
        end
    end

    assign load     = (r_state == ST_LOAD);
    assign running  = (r_state == ST_RUN);
    assign paused   = (r_state == ST_PAUSE);
    assign cnt_en   = (r_state == ST_RUN) && w_wrap && !time_out;
    assign alarm    = r_alarm;
    assign err      = r_err;
    assign min_Init = r_min;

endmodule
